// File: rtl/gray_counter.sv
// gray_counter: clocked Gray-code pointer unit for asynchronous FIFOs.
// Keeps a binary count and its Gray image in lock-step registers, and also
// synchronises and decodes a Gray pointer arriving from another clock domain.
//
// Configuration macro: GRAY_COUNTER_SAT_EN
//   undefined (default) - modulo counting; wrap pulses on each roll-over.
//   defined             - saturating counting; wrap flags a pinned counter
//                         for every enabled cycle it sits at a limit.
module gray_counter #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] gray_in_bin
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Binary to reflected Gray code.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code back to binary: each bit folds in all higher bits.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = ALL_ZERO;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] gray_in_bin_q;
    logic [WIDTH-1:0] gray_in_bin_d;

    // Next count: load beats enable beats hold; Gray derives from next binary.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d  = load_bin;
            wrap_d = 1'b0;
        end else if (en) begin
            if (up) begin
                if (bin_q == ALL_ONES) begin
`ifdef GRAY_COUNTER_SAT_EN
                    bin_d  = ALL_ONES;
                    wrap_d = 1'b1;
`else
                    bin_d  = ALL_ZERO;
                    wrap_d = 1'b1;
`endif
                end else begin
                    bin_d  = bin_q + ONE;
                    wrap_d = 1'b0;
                end
            end else begin
                if (bin_q == ALL_ZERO) begin
`ifdef GRAY_COUNTER_SAT_EN
                    bin_d  = ALL_ZERO;
                    wrap_d = 1'b1;
`else
                    bin_d  = ALL_ONES;
                    wrap_d = 1'b1;
`endif
                end else begin
                    bin_d  = bin_q - ONE;
                    wrap_d = 1'b0;
                end
            end
        end else begin
            bin_d  = bin_q;
            wrap_d = 1'b0;
        end
        gray_d = bin2gray(bin_d);
    end

    // Counter registers: binary and Gray always commit on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= ALL_ZERO;
            gray_q <= ALL_ZERO;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    // Synchroniser shift and decode of the last stage.
    always_comb begin
        sync_d[0] = gray_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        gray_in_bin_d = gray2bin(sync_q[SYNC_STAGES-1]);
    end

    // Synchroniser chain and registered decode; shifts every edge, no enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= ALL_ZERO;
            end
            gray_in_bin_q <= ALL_ZERO;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            gray_in_bin_q <= gray_in_bin_d;
        end
    end

    assign bin         = bin_q;
    assign gray        = gray_q;
    assign wrap        = wrap_q;
    assign gray_in_bin = gray_in_bin_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (WIDTH = 4, SYNC_STAGES = 2).
module tb_gray_counter;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;
    localparam int MOD   = 1 << WIDTH;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             wrap;
    logic [WIDTH-1:0] gray_in;
    logic [WIDTH-1:0] gray_in_bin;

    int checks;
    int failures;

    // reference model state
    int m_bin;
    int m_wrap;
    int m_gib;
    int gq[$];

    gray_counter #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_bin(load_bin), .bin(bin), .gray(gray), .wrap(wrap),
        .gray_in(gray_in), .gray_in_bin(gray_in_bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // decode by searching for the binary value whose Gray image matches
    function automatic int from_gray(input int g);
        for (int v = 0; v < MOD; v++) begin
            if (to_gray(v) == g) return v;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bin  = 0;
        m_wrap = 0;
        m_gib  = 0;
        gq.delete();
        for (int i = 0; i < SYNC; i++) gq.push_back(0);
    endtask

    task automatic model_edge(input int l, input int lb, input int e, input int u, input int gi);
        int nb;
        int v;
        if (l != 0) begin
            m_bin  = lb;
            m_wrap = 0;
        end else if (e != 0) begin
            nb = (u != 0) ? m_bin + 1 : m_bin - 1;
            if (nb < 0 || nb >= MOD) begin
`ifdef GRAY_COUNTER_SAT_EN
                m_wrap = 1;
`else
                m_bin  = (nb + MOD) % MOD;
                m_wrap = 1;
`endif
            end else begin
                m_bin  = nb;
                m_wrap = 0;
            end
        end else begin
            m_wrap = 0;
        end
        gq.push_back(gi);
        v = gq.pop_front();
        m_gib = from_gray(v);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".bin"},  32'(bin),         32'(m_bin));
        check({tag, ".gray"}, 32'(gray),        32'(to_gray(m_bin)));
        check({tag, ".wrap"}, 32'(wrap),        32'(m_wrap));
        check({tag, ".gib"},  32'(gray_in_bin), 32'(m_gib));
    endtask

    // one clock edge: capture the applied inputs, advance model, compare
    task automatic step(input string tag);
        int l, lb, e, u, gi;
        l = int'(load); lb = int'(load_bin); e = int'(en); u = int'(up); gi = int'(gray_in);
        @(posedge clk);
        #1;
        model_edge(l, lb, e, u, gi);
        check_all(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] prev_gray;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_bin = 4'd0;
        gray_in  = 4'd0;
        model_reset();

        // reset state
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // up sweep, 17 edges from 0, one Gray bit per step
        en = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 17; i++) begin
            prev_gray = gray;
            step("up_sweep");
            check("up_onebit", 32'($countones(gray ^ prev_gray)), 32'd1);
            if (i == 15) check("up_wrap_15_0", 32'(wrap), 32'd1);
        end

        // down sweep: load 2 then three down edges 1, 0, 15
        en = 1'b0; load = 1'b1; load_bin = 4'd2;
        step("down_load");
        load = 1'b0; en = 1'b1; up = 1'b0;
        step("down1");
        step("down2");
        step("down3");
        check("down_gray_1000", 32'(gray), 32'h8);
        check("down_wrap", 32'(wrap), 32'd1);
        en = 1'b0;
        step("down_hold");

        // priority: load beats en at bin = 15
        load = 1'b1; load_bin = 4'd15;
        step("prio_pre");
        en = 1'b1; up = 1'b1; load_bin = 4'd6;
        step("prio");
        check("prio_gray_0101", 32'(gray), 32'h5);
        load = 1'b0; en = 1'b0;

        // decode: hold 1101, appears as 1001 after three edges
        gray_in = 4'b1101;
        step("dec1");
        check("dec1_zero", 32'(gray_in_bin), 32'd0);
        step("dec2");
        check("dec2_zero", 32'(gray_in_bin), 32'd0);
        step("dec3");
        check("dec3_1001", 32'(gray_in_bin), 32'h9);

        // asynchronous reset mid-count at bin = 9
        load = 1'b1; load_bin = 4'd8;
        step("mid_load");
        load = 1'b0; en = 1'b1; up = 1'b1;
        step("mid_count");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            load     = ($urandom_range(0, 9) == 0);
            load_bin = WIDTH'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            up       = $urandom_range(0, 1) == 1;
            gray_in  = WIDTH'($urandom);
            step("rand");
        end

`ifdef GRAY_COUNTER_SAT_EN
        // saturation: load 14, up three edges, then release enable
        load = 1'b1; en = 1'b0; load_bin = 4'd14;
        step("sat_load");
        load = 1'b0; en = 1'b1; up = 1'b1;
        step("sat1");
        check("sat1_wrap0", 32'(wrap), 32'd0);
        step("sat2");
        check("sat2_wrap1", 32'(wrap), 32'd1);
        step("sat3");
        check("sat3_bin15", 32'(bin), 32'hf);
        en = 1'b0;
        step("sat_off");
        check("sat_off_wrap0", 32'(wrap), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
